// File: rtl/stopwatch_clock_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_clock_pkg
// Shared definitions for the clock path of the stopwatch/clock design:
//   - clk_set_state_t : time-setting FSM state encodings
//   - FIELD_*         : o_field codes seen by the FND controller
//   - DEF_*           : default timing constants (100 MHz system clock)
//   - field_of()      : maps an FSM state to its field code
//   - cnt_width()     : counter width for a given cycle count (never 0)
// -----------------------------------------------------------------------------
package stopwatch_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_SET_SEC  = 2'b11
  } clk_set_state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_SEC  = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_HOUR = 2'b11;

  localparam int unsigned DEF_BLINK_HALF_CYC   = 32'd50_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC      = 32'd1_000_000_000;
  localparam int unsigned DEF_REPEAT_DELAY_CYC = 32'd50_000_000;
  localparam int unsigned DEF_REPEAT_RATE_CYC  = 32'd10_000_000;

  function automatic logic [1:0] field_of(input clk_set_state_t s);
    logic [1:0] f;
    case (s)
      ST_SET_HOUR: f = FIELD_HOUR;
      ST_SET_MIN:  f = FIELD_MIN;
      ST_SET_SEC:  f = FIELD_SEC;
      default:     f = FIELD_NONE;
    endcase
    return f;
  endfunction

  // A cycle count of 1 would give $clog2 = 0; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned max_cyc);
    int unsigned w;
    if (max_cyc > 32'd1) begin
      w = $clog2(max_cyc);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Saturating up-counter used for the blink phase, the edit inactivity timeout
// and the auto-repeat timing. Counts 0 .. MAX_CYC-1 and then holds, so it can
// never wrap into a second terminal-count event on its own.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   i_clr    : synchronous clear (wins over i_en)
//   i_en     : count enable
//   o_tc     : high while the count equals MAX_CYC-1
// -----------------------------------------------------------------------------
module cycle_timer
  import stopwatch_clock_pkg::*;
#(
  parameter int unsigned MAX_CYC = 32'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned W = cnt_width(MAX_CYC);
  localparam logic [W-1:0] LAST = W'(MAX_CYC - 32'd1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, count up, or hold at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting controller between the button controller and the clock counter.
// The edit button walks IDLE -> SET_HOUR -> SET_MIN -> SET_SEC -> IDLE; the up
// button produces one increment pulse for the selected field. While editing the
// clock seconds tick is paused and the selected field blinks. An inactivity
// timeout drops back to IDLE.
//
// Optional feature: define CLOCK_SET_AUTOREPEAT_EN to enable held-button
// auto-repeat driven by i_btn_up_level. Without it that input is ignored.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_clock_mode    : 1 = clock display mode; 0 forces IDLE
//   i_btn_edit      : single-cycle pulse, advances the edit field
//   i_btn_up        : single-cycle pulse, increments the selected field
//   i_btn_up_level  : held level of the up button (auto-repeat only)
//   o_inc_hour/min/sec : single-cycle increment pulses (registered)
//   o_editing       : high in any SET state
//   o_field         : 00 none, 01 sec, 10 min, 11 hour
//   o_blank         : FND blanks the selected field this phase
//   o_pause         : holds the clock seconds tick (same as o_editing)
// -----------------------------------------------------------------------------
module clock_set_ctrl
  import stopwatch_clock_pkg::*;
#(
  parameter int unsigned BLINK_HALF_CYC   = DEF_BLINK_HALF_CYC,
  parameter int unsigned TIMEOUT_CYC      = DEF_TIMEOUT_CYC,
  parameter int unsigned REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int unsigned REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clock_mode,
  input  logic       i_btn_edit,
  input  logic       i_btn_up,
  input  logic       i_btn_up_level,
  output logic       o_inc_hour,
  output logic       o_inc_min,
  output logic       o_inc_sec,
  output logic       o_editing,
  output logic [1:0] o_field,
  output logic       o_blank,
  output logic       o_pause
);

  clk_set_state_t state_q;
  clk_set_state_t state_d;

  logic       inc_hour_q, inc_hour_d;
  logic       inc_min_q,  inc_min_d;
  logic       inc_sec_q,  inc_sec_d;
  logic       editing_q,  editing_d;
  logic [1:0] field_q,    field_d;
  logic       blank_q,    blank_d;
  logic       pause_q,    pause_d;

  logic in_set_s;
  logic up_acc_s;      // up pulse that actually produces an increment
  logic rep_fire_s;    // auto-repeat increment this cycle
  logic activity_s;    // any button activity that holds off the timeout
  logic restart_s;     // blink phase restarts at visible
  logic tmo_tc_s;
  logic tmo_clr_s;
  logic blink_tc_s;
  logic blink_clr_s;

  // Qualified button events; edit has priority over up in the same cycle.
  always_comb begin
    in_set_s   = (state_q != ST_IDLE);
    up_acc_s   = in_set_s && i_clock_mode && !i_btn_edit && i_btn_up;
    activity_s = i_btn_edit || i_btn_up || rep_fire_s;
  end

  // Next-state logic: mode exit, then edit sequencing, then timeout.
  always_comb begin
    state_d = state_q;
    if (!i_clock_mode) begin
      state_d = ST_IDLE;
    end else if (i_btn_edit) begin
      case (state_q)
        ST_IDLE:     state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        ST_SET_MIN:  state_d = ST_SET_SEC;
        ST_SET_SEC:  state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end else if (in_set_s && tmo_tc_s && !activity_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Counter control. Both counters sit at 0 in IDLE and restart on any field
  // change; the blink counter also restarts on its own terminal count so the
  // half-period repeats.
  always_comb begin
    restart_s   = (state_d == ST_IDLE) || (state_d != state_q) ||
                  up_acc_s || rep_fire_s;
    tmo_clr_s   = (state_d == ST_IDLE) || (state_d != state_q) || activity_s;
    blink_clr_s = restart_s || blink_tc_s;
  end

  // Registered output values.
  always_comb begin
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    inc_sec_d  = 1'b0;
    if (up_acc_s || rep_fire_s) begin
      case (state_q)
        ST_SET_HOUR: inc_hour_d = 1'b1;
        ST_SET_MIN:  inc_min_d  = 1'b1;
        ST_SET_SEC:  inc_sec_d  = 1'b1;
        default: begin
          inc_hour_d = 1'b0;
          inc_min_d  = 1'b0;
          inc_sec_d  = 1'b0;
        end
      endcase
    end else begin
      inc_hour_d = 1'b0;
      inc_min_d  = 1'b0;
      inc_sec_d  = 1'b0;
    end

    editing_d = (state_d != ST_IDLE);
    pause_d   = (state_d != ST_IDLE);
    field_d   = field_of(state_d);

    if (restart_s) begin
      blank_d = 1'b0;
    end else if (blink_tc_s) begin
      blank_d = !blank_q;
    end else begin
      blank_d = blank_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      inc_sec_q  <= 1'b0;
      editing_q  <= 1'b0;
      field_q    <= FIELD_NONE;
      blank_q    <= 1'b0;
      pause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inc_hour_q <= inc_hour_d;
      inc_min_q  <= inc_min_d;
      inc_sec_q  <= inc_sec_d;
      editing_q  <= editing_d;
      field_q    <= field_d;
      blank_q    <= blank_d;
      pause_q    <= pause_d;
    end
  end

  cycle_timer #(.MAX_CYC(TIMEOUT_CYC)) u_tmo_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (tmo_clr_s),
    .i_en  (in_set_s),
    .o_tc  (tmo_tc_s)
  );

  cycle_timer #(.MAX_CYC(BLINK_HALF_CYC)) u_blink_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (blink_clr_s),
    .i_en  (1'b1),
    .o_tc  (blink_tc_s)
  );

`ifdef CLOCK_SET_AUTOREPEAT_EN
  // Auto-repeat: rep_arm_q is set by an accepted up pulse and held while the
  // level stays high; rep_fast_q marks that the initial delay has elapsed and
  // the faster repeat period applies.
  logic rep_arm_q,  rep_arm_d;
  logic rep_fast_q, rep_fast_d;
  logic rep_dly_tc_s;
  logic rep_dly_clr_s;
  logic rep_rate_tc_s;
  logic rep_rate_clr_s;

  // A repeat is only allowed where a fresh up pulse would also be accepted.
  assign rep_fire_s = rep_arm_q && i_btn_up_level && in_set_s && i_clock_mode &&
                      !i_btn_edit && !i_btn_up &&
                      ((!rep_fast_q && rep_dly_tc_s) || (rep_fast_q && rep_rate_tc_s));

  // Repeat arming and phase.
  always_comb begin
    if ((state_d == ST_IDLE) || !i_clock_mode || i_btn_edit) begin
      rep_arm_d = 1'b0;
    end else if (up_acc_s) begin
      rep_arm_d = 1'b1;
    end else if (!i_btn_up_level) begin
      rep_arm_d = 1'b0;
    end else begin
      rep_arm_d = rep_arm_q;
    end

    if (!rep_arm_d || up_acc_s) begin
      rep_fast_d = 1'b0;
    end else if (rep_fire_s) begin
      rep_fast_d = 1'b1;
    end else begin
      rep_fast_d = rep_fast_q;
    end

    rep_dly_clr_s  = !rep_arm_q || rep_fast_q || up_acc_s;
    rep_rate_clr_s = !rep_fast_q || rep_fire_s;
  end

  // Repeat control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_arm_q  <= 1'b0;
      rep_fast_q <= 1'b0;
    end else begin
      rep_arm_q  <= rep_arm_d;
      rep_fast_q <= rep_fast_d;
    end
  end

  cycle_timer #(.MAX_CYC(REPEAT_DELAY_CYC)) u_rep_dly_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (rep_dly_clr_s),
    .i_en  (i_btn_up_level),
    .o_tc  (rep_dly_tc_s)
  );

  cycle_timer #(.MAX_CYC(REPEAT_RATE_CYC)) u_rep_rate_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (rep_rate_clr_s),
    .i_en  (1'b1),
    .o_tc  (rep_rate_tc_s)
  );
`else
  // Without auto-repeat the held level has no function.
  logic unused_up_level_s;
  assign unused_up_level_s = i_btn_up_level;
  assign rep_fire_s        = 1'b0;
`endif

  assign o_inc_hour = inc_hour_q;
  assign o_inc_min  = inc_min_q;
  assign o_inc_sec  = inc_sec_q;
  assign o_editing  = editing_q;
  assign o_field    = field_q;
  assign o_blank    = blank_q;
  assign o_pause    = pause_q;

endmodule
